// File: rtl/branch_sequencer.sv
// branch_sequencer: walks a conditional branch (brzr/brnz/brpl/brmi) through
// execute steps T3..T6, raising datapath strobes and latching the condition.
module branch_sequencer #(
    parameter logic SKIP_NOT_TAKEN = 1'b1,
    parameter int   CNT_W          = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [31:0]      IR,
    input  logic [31:0]      BusMuxOut,
    output logic             busy,
    output logic             done,
    output logic             con_out,
    output logic             Gra,
    output logic             Rout,
    output logic             CONin,
    output logic             PCout,
    output logic             Yin,
    output logic             Cout,
    output logic             ADD,
    output logic             Zin,
    output logic             Zlowout,
    output logic             PCin,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nottaken_cnt,
    output logic [2:0]       state_dbg
);

    // Launch handshake: start is a one-cycle request taken only while busy=0;
    // busy stays high from T3 through DONE, and done pulses once in DONE.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T3   = 3'd1,
        S_T4   = 3'd2,
        S_T5   = 3'd3,
        S_T6   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    state_t state_nxt;
    logic   cond_true;
    logic   unused_ir;

    // Only the condition field of IR matters here.
    assign unused_ir = ^{IR[31:21], IR[18:0]};

    always_comb begin
        cond_true = 1'b0;
        case (IR[20:19])
            2'b00:   cond_true = (BusMuxOut == 32'd0);
            2'b01:   cond_true = (BusMuxOut != 32'd0);
            2'b10:   cond_true = ~BusMuxOut[31];
            default: cond_true = BusMuxOut[31];
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_T3;
            S_T3: begin
                if (SKIP_NOT_TAKEN && !cond_true) state_nxt = S_DONE;
                else                              state_nxt = S_T4;
            end
            S_T4:    state_nxt = S_T5;
            S_T5:    state_nxt = S_T6;
            S_T6:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        Gra     = 1'b0;
        Rout    = 1'b0;
        CONin   = 1'b0;
        PCout   = 1'b0;
        Yin     = 1'b0;
        Cout    = 1'b0;
        ADD     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        PCin    = 1'b0;
        case (state)
            S_T3: begin
                Gra   = 1'b1;
                Rout  = 1'b1;
                CONin = 1'b1;
            end
            S_T4: begin
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            S_T5: begin
                Cout = 1'b1;
                ADD  = 1'b1;
                Zin  = 1'b1;
            end
            S_T6: begin
                Zlowout = 1'b1;
                PCin    = con_out;
            end
            default: ;
        endcase
    end

    // Condition and statistics update together on the edge that leaves T3.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            con_out      <= 1'b0;
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else if (state == S_T3) begin
            con_out <= cond_true;
            if (cond_true) begin
                if (taken_cnt != CNT_MAX) taken_cnt <= taken_cnt + CNT_ONE;
            end else begin
                if (nottaken_cnt != CNT_MAX) nottaken_cnt <= nottaken_cnt + CNT_ONE;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Clocked controller that sequences a conditional-branch instruction (brzr/brnz/brpl/brmi) through the datapath during execute steps T3–T6. It issues the register-read, condition-capture, PC-add and PC-load control strobes, and evaluates the branch condition into a registered CON flag. It sits between the control unit, which launches it with `start`, and the datapath bus. It also keeps saturating taken/not-taken counters for debug.

## Interface
- `SKIP_NOT_TAKEN`, default 1: if 1, a not-taken branch skips the PC-add steps and completes early.
- `CNT_W`, default 16: width of each statistics counter.

- `clock`  in  1: rising-edge clock.
- `clear`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle launch request from the control unit. Honoured only in IDLE.
- `IR`  in  32: instruction register. IR[20:19] selects the condition; it must be held stable while `busy`=1.
- `BusMuxOut`  in  32: datapath bus value. It carries R[Ra] during T3.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse on completion.
- `con_out`  out  1: registered branch condition.
- `Gra`, `Rout`, `CONin`  out  1 each: T3 strobes.
- `PCout`, `Yin`  out  1 each: T4 strobes.
- `Cout`, `ADD`, `Zin`  out  1 each: T5 strobes.
- `Zlowout`, `PCin`  out  1 each: T6 strobes. `PCin` is asserted only if `con_out`=1.
- `taken_cnt`, `nottaken_cnt`  out  CNT_W each: saturating event counters.

## Operation
- States: IDLE, T3, T4, T5, T6, DONE. Encoding is free. State and outputs are registered; strobes are Moore-decoded from state.
- IDLE: `start`=1 moves to T3; otherwise stay in IDLE.
- T3:
  - assert `Gra`, `Rout`, `CONin`;
  - at the clock edge ending T3, evaluate the condition from `BusMuxOut` and IR[20:19] and load the result into `con_out`.
- Condition codes:
  - 00: zero, `BusMuxOut`==0;
  - 01: nonzero, `BusMuxOut`!=0;
  - 10: positive, `BusMuxOut`[31]==0;
  - 11: negative, `BusMuxOut`[31]==1.
- From T3: if SKIP_NOT_TAKEN=1 and the condition evaluated false, go to DONE; otherwise go to T4.
- T4 → T5 → T6 → DONE, unconditionally.
- T6: assert `Zlowout`; assert `PCin` iff `con_out`=1.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `con_out` holds its value until the next T3 edge. It is not cleared on return to IDLE.
- Counters:
  - at the T3 exit edge, increment `taken_cnt` if the condition is true, else increment `nottaken_cnt`;
  - each counter saturates at 2^CNT_W−1 and never wraps.
- `start` while `busy`=1 is ignored: no queuing, no error.
- At most one strobe group is active per cycle. No strobe is asserted in IDLE or DONE.

## Timing
- Reset (`clear`=1, asynchronous):
  - state goes to IDLE;
  - `con_out`, `taken_cnt`, `nottaken_cnt` go to 0;
  - all strobes, `busy` and `done` go to 0 immediately, without waiting for a clock edge.
- Reset mid-sequence aborts the sequence. No further strobes are issued, and no `done` is produced for the aborted branch.
- Latency from the `start` edge to the `done` pulse:
  - taken branch, or any branch with SKIP_NOT_TAKEN=0: 5 cycles (T3, T4, T5, T6, then DONE);
  - not-taken branch with SKIP_NOT_TAKEN=1: 2 cycles (T3, then DONE).
- `busy` rises in the cycle after `start` is sampled and falls in the cycle after DONE.
- Back-to-back: `start` asserted in the cycle after DONE (state IDLE) is accepted. Minimum issue interval is 3 cycles for a skipped not-taken branch and 6 cycles otherwise.
- `BusMuxOut` is sampled only at the T3 exit edge. Values at any other time have no effect.
- `start` and `clear` asserted together: `clear` wins.

## Test plan
- Reset: assert `clear` mid-T5 → all outputs 0 asynchronously; the next `start` runs a full clean sequence from T3.
- brzr taken: IR[20:19]=00, `BusMuxOut`=0x00000000 → `con_out`=1; `PCin`=1 in T6; `done` 5 cycles after `start`; `taken_cnt`=1.
- brnz not taken, SKIP_NOT_TAKEN=1: IR[20:19]=01, `BusMuxOut`=0 → `con_out`=0; no T4–T6 strobes; `done` 2 cycles after `start`; `nottaken_cnt`=1.
- brpl/brmi boundaries:
  - `BusMuxOut`=0x80000000 with code 10 → not taken; with code 11 → taken;
  - `BusMuxOut`=0x7FFFFFFF with code 10 → taken;
  - with SKIP_NOT_TAKEN=0 a not-taken branch still walks T4–T6, with `PCin`=0 in T6.
- Busy handling: pulse `start` during T4 → ignored, exactly one `done`. Re-pulse `start` in the first IDLE cycle → accepted.
- Saturation: CNT_W=2, run 5 taken branches → `taken_cnt` stops at 3; `nottaken_cnt` stays 0.
